// File: rtl/fir_arb_pkg.sv
// Shared types and defaults for the FIR requester arbiter.
// The timeout default is only present when FIR_ARB_TIMEOUT_EN is defined.
package fir_arb_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_COEF_DEF = 4;
`ifdef FIR_ARB_TIMEOUT_EN
    localparam int TIMEOUT_CYC_DEF = 64;
`endif

    typedef enum logic [1:0] {
        ARB   = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10,
        CWAIT = 2'b11
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_SAMP = 2'b01,
        GNT_COEF = 2'b10
    } grant_e;

    // Burst counter width; a single-word burst still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_req_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the requester that was not granted last wins.
module rr_pick2
    import fir_arb_pkg::*;
(
    input  logic   samp_valid_i,
    input  logic   coef_valid_i,
    input  grant_e last_grant_i,
    output grant_e pick_o
);

    // Pick a requester from the valids and the previous grant.
    always_comb begin
        pick_o = GNT_NONE;
        if (samp_valid_i && coef_valid_i) begin
            pick_o = (last_grant_i == GNT_SAMP) ? GNT_COEF : GNT_SAMP;
        end else if (samp_valid_i) begin
            pick_o = GNT_SAMP;
        end else if (coef_valid_i) begin
            pick_o = GNT_COEF;
        end else begin
            pick_o = GNT_NONE;
        end
    end

endmodule

// File: rtl/fir_req_arbiter.sv
// Arbitrates sample and coefficient streams onto the shared FIR bus with dr/lc strobes.
// Optional watchdog enabled by defining FIR_ARB_TIMEOUT_EN.
module fir_req_arbiter
    import fir_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_COEF = NUM_COEF_DEF
`ifdef FIR_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       samp_valid,
    input  logic [DATA_W-1:0]          samp_data,
    output logic                       samp_ready,
    input  logic                       coef_valid,
    input  logic [DATA_W-1:0]          coef_data,
    output logic                       coef_ready,
    input  logic                       modwait,
    input  logic                       err,
    output logic                       dr,
    output logic                       lc,
    output logic [DATA_W-1:0]          data_out,
    output logic [1:0]                 grant,
    output logic [cnt_w(NUM_COEF)-1:0] burst_cnt,
    output logic                       arb_err
);

    localparam int CNT_W = cnt_w(NUM_COEF);

    arb_state_e        state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            pick_s;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              arb_err_q, arb_err_d;
    logic              samp_ready_s, coef_ready_s;

`ifdef FIR_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

    rr_pick2 u_pick (
        .samp_valid_i (samp_valid),
        .coef_valid_i (coef_valid),
        .last_grant_i (last_grant_q),
        .pick_o       (pick_s)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        data_d       = data_q;
        arb_err_d    = arb_err_q;
        samp_ready_s = 1'b0;
        coef_ready_s = 1'b0;

        case (state_q)
            ARB: begin
                grant_d = GNT_NONE;
                // A busy controller (another source) blocks any new grant.
                if (!modwait && (pick_s != GNT_NONE)) begin
                    if (pick_s == GNT_SAMP) begin
                        samp_ready_s = 1'b1;
                        data_d       = samp_data;
                    end else begin
                        coef_ready_s = 1'b1;
                        data_d       = coef_data;
                    end
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    burst_cnt_d  = '0;
                    arb_err_d    = 1'b0;
                    state_d      = ISSUE;
                end else begin
                    state_d = ARB;
                end
            end
            ISSUE: begin
                if (modwait) begin
                    state_d = BUSY;
                end else begin
                    state_d = ISSUE;
                end
            end
            BUSY: begin
                if (!modwait) begin
                    if (err) begin
                        arb_err_d   = 1'b1;
                        burst_cnt_d = '0;
                        grant_d     = GNT_NONE;
                        state_d     = ARB;
                    end else if ((grant_q == GNT_COEF) &&
                                 (burst_cnt_q != CNT_W'(NUM_COEF - 1))) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                        state_d     = CWAIT;
                    end else begin
                        burst_cnt_d = '0;
                        grant_d     = GNT_NONE;
                        state_d     = ARB;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            CWAIT: begin
                // The burst owns the bus; sample requests are ignored here.
                if (coef_valid) begin
                    coef_ready_s = 1'b1;
                    data_d       = coef_data;
                    arb_err_d    = 1'b0;
                    state_d      = ISSUE;
                end else begin
                    state_d = CWAIT;
                end
            end
            default: begin
                grant_d     = GNT_NONE;
                burst_cnt_d = '0;
                state_d     = ARB;
            end
        endcase

`ifdef FIR_ARB_TIMEOUT_EN
        if ((state_q != ARB) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
            samp_ready_s = 1'b0;
            coef_ready_s = 1'b0;
            data_d       = data_q;
            arb_err_d    = 1'b1;
            burst_cnt_d  = '0;
            grant_d      = GNT_NONE;
            state_d      = ARB;
        end else begin
            arb_err_d = arb_err_d;
        end
`endif
    end

`ifdef FIR_ARB_TIMEOUT_EN
    // Watchdog counts cycles spent in one non-idle state.
    always_comb begin
        tmo_d = '0;
        if ((state_q != ARB) && (state_d == state_q)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end else begin
            tmo_d = '0;
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ARB;
            grant_q      <= GNT_NONE;
            last_grant_q <= GNT_COEF;
            burst_cnt_q  <= '0;
            data_q       <= '0;
            arb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            data_q       <= data_d;
            arb_err_q    <= arb_err_d;
        end
    end

    assign samp_ready = samp_ready_s;
    assign coef_ready = coef_ready_s;
    assign dr         = (state_q == ISSUE) && (grant_q == GNT_SAMP);
    assign lc         = (state_q == ISSUE) && (grant_q == GNT_COEF);
    assign data_out   = data_q;
    assign grant      = grant_q;
    assign burst_cnt  = burst_cnt_q;
    assign arb_err    = arb_err_q;

endmodule

// File: doc/fir_req_arbiter.md
Name: fir_req_arbiter

Overview:
Shares the FIR filter controller and datapath between two requesters: a sample stream and a coefficient-load stream.
- Accepts a word from one requester at a time and drives the shared 16-bit data bus.
- Issues dr (sample) or lc (coefficient) strobes using the controller's modwait handshake.
- Locks the grant for a full NUM_COEF-word coefficient burst.
- Sits between the input FIFOs and the FIR controller/datapath.

Parameters:
DATA_W, 16, width of sample/coefficient words
NUM_COEF, 4, coefficient words per lc burst (counter width = clog2(NUM_COEF))
TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
samp_valid  in  1  sample requester has a word
samp_data  in  DATA_W  sample word
samp_ready  out  1  sample word accepted this cycle
coef_valid  in  1  coefficient requester has a word
coef_data  in  DATA_W  coefficient word
coef_ready  out  1  coefficient word accepted this cycle
modwait  in  1  controller busy flag
err  in  1  controller error flag
dr  out  1  data-ready strobe to controller
lc  out  1  load-coefficient strobe to controller
data_out  out  DATA_W  registered word on the shared bus
grant  out  2  01 = sample, 10 = coefficient, 00 = none
burst_cnt  out  clog2(NUM_COEF)  coefficient index within burst
arb_err  out  1  sticky error; cleared on next accepted word

Behaviour:
- Reset values: state ARB, all outputs 0, last_grant = coefficient (so sample wins the first tie).
- States: ARB, ISSUE, BUSY, CWAIT.
- ARB:
  - If exactly one valid, grant it.
  - If both valid, grant the requester not in last_grant (round-robin).
  - Mid-burst coefficient grants are never pre-empted.
  - On grant: assert the matching ready for exactly 1 cycle, register the data into data_out, update grant and last_grant, clear arb_err, then go to ISSUE.
  - No valid: stay in ARB with grant=00.
- ISSUE:
  - Drive dr (sample grant) or lc (coefficient grant) combinationally from state; never both.
  - Stay while modwait=0.
  - On modwait=1, go to BUSY; the strobe stays high through that cycle.
  - Net effect: the strobe is high for at least 2 cycles, covering the controller's second dr check.
- BUSY:
  - Strobes low; wait for modwait=0.
  - If err=1 in that cycle, set arb_err and end any burst.
  - Sample grant: go to ARB.
  - Coefficient grant with burst_cnt < NUM_COEF-1: increment burst_cnt and go to CWAIT.
  - Coefficient grant with burst_cnt = NUM_COEF-1: reset burst_cnt to 0 and go to ARB.
- CWAIT:
  - Wait for coef_valid while samp_valid is ignored.
  - On coef_valid: pulse coef_ready, register the data, go to ISSUE.
- data_out is stable from acceptance until the next acceptance.
- modwait=1 seen in ARB (controller busy from another source): do not grant; wait.
- Reset mid-burst: immediate return to ARB with burst_cnt=0. Any word accepted but not yet issued is discarded.

Optional Feature:
FIR_ARB_TIMEOUT_EN
- Defined: a cycle counter runs in ISSUE, BUSY and CWAIT and clears on each state change. Reaching TIMEOUT_CYC sets arb_err, drops both strobes, sets burst_cnt=0 and returns to ARB.
- Undefined: no counter; the block waits indefinitely.

Decomposition:
- Package fir_arb_pkg: state enum (ARB, ISSUE, BUSY, CWAIT), grant encodings (GNT_NONE, GNT_SAMP, GNT_COEF), default NUM_COEF.
- Optional sub-module rr_pick2: combinational two-way round-robin selector taking the two valids and last_grant.
- Everything else stays in one module.

Test Plan:
- Single sample 0x1234, modwait rises 1 cycle after dr and falls 12 cycles later -> samp_ready 1-cycle pulse, data_out=0x1234, dr high exactly 2 cycles, grant returns to 00.
- Coefficient burst of 0x0001..0x0004 with a 3-cycle coef_valid gap before word 3, samp_valid held high throughout -> four lc issues, burst_cnt 0,1,2,3, no samp_ready until the burst ends.
- Both valid every cycle for 6 transactions -> grants alternate sample, coefficient-burst, sample, …; sample granted first after reset.
- err=1 when modwait falls on sample 0x7FFF -> arb_err=1, stays set until the next acceptance, then clears.
- Reset asserted in BUSY during coefficient word 2 -> next cycle: ARB, burst_cnt=0, dr=lc=0, grant=00.
- With FIR_ARB_TIMEOUT_EN and TIMEOUT_CYC=64, modwait held 0 after a dr issue -> after 64 cycles arb_err=1, dr=0, state returns to ARB.
